// File: rtl/ram_bist_pkg.sv
// Shared types and default sizes for the March-test RAM BIST.
package ram_bist_pkg;

    localparam int AW_DEFAULT = 8;
    localparam int DW_DEFAULT = 8;

    // March elements; IDLE and DONE bracket the test.
    typedef enum logic [2:0] {
        IDLE,
        W0,
        R0W1,
        R1W0,
        RFIN,
        DONE
    } state_t;

endpackage

// File: rtl/bist_addr_cnt.sv
// Up/down RAM address counter with load-to-bottom/top and terminal-count flags.
module bist_addr_cnt
    import ram_bist_pkg::*;
#(
    parameter int AW = AW_DEFAULT
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          load_lo,
    input  logic          load_hi,
    input  logic          inc,
    input  logic          dec,
    output logic [AW-1:0] addr,
    output logic          at_max,
    output logic          at_min
);

    logic [AW-1:0] cnt_q;
    logic [AW-1:0] cnt_d;

    // Next count: loads win over stepping; holds when no command is given.
    always_comb begin
        cnt_d = cnt_q;
        if (load_lo) begin
            cnt_d = '0;
        end else if (load_hi) begin
            cnt_d = '1;
        end else if (inc) begin
            cnt_d = cnt_q + AW'(1);
        end else if (dec) begin
            cnt_d = cnt_q - AW'(1);
        end
    end

    // Count register with synchronous reset.
    always_ff @(posedge CLK) begin
        // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
        if (RST) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign addr   = cnt_q;
    assign at_max = &cnt_q;
    assign at_min = ~|cnt_q;

endmodule

// File: rtl/ram_bist.sv
// March-test BIST initiator for a single-port synchronous RAM with 1-cycle read latency.
// Elements: W0 (up, write P), R0W1 (up, read P / write ~P), R1W0 (down, read ~P / write P),
// RFIN (down, pipelined read P). The first mismatch ends the test early.
module ram_bist
    import ram_bist_pkg::*;
#(
    parameter int AW = AW_DEFAULT,
    parameter int DW = DW_DEFAULT
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          Start,
    input  logic [DW-1:0] Pattern,
    output logic          RAM_EN,
    output logic          RAM_WE,
    output logic [AW-1:0] RAM_Addr,
    output logic [DW-1:0] RAM_Din,
    input  logic [DW-1:0] RAM_Dout,
    output logic          Busy,
    output logic          Done,
    output logic          Pass,
    output logic [AW-1:0] FailAddr,
    output logic [DW-1:0] FailData
);

    state_t        state_q, state_d;
    logic          phase_q, phase_d;          // 0: read cycle A, 1: compare/write cycle B
    logic          tail_q, tail_d;            // RFIN compare-only final cycle
    logic          rd_vld_q, rd_vld_d;        // RFIN read issued last cycle
    logic [AW-1:0] rd_addr_q, rd_addr_d;      // address of that RFIN read
    logic [DW-1:0] pat_q, pat_d;
    logic          pass_q, pass_d;
    logic [AW-1:0] fail_addr_q, fail_addr_d;
    logic [DW-1:0] fail_data_q, fail_data_d;

    logic          cnt_load_lo, cnt_load_hi, cnt_inc, cnt_dec;
    logic [AW-1:0] addr;
    logic          at_max, at_min;

    logic          cmp_en;
    logic [DW-1:0] exp_word;
    logic [AW-1:0] cmp_addr;
    logic          mismatch;
    logic          ram_en, ram_we;
    logic [DW-1:0] ram_din;

    bist_addr_cnt #(.AW(AW)) u_addr_cnt (
        .CLK     (CLK),
        .RST     (RST),
        .load_lo (cnt_load_lo),
        .load_hi (cnt_load_hi),
        .inc     (cnt_inc),
        .dec     (cnt_dec),
        .addr    (addr),
        .at_max  (at_max),
        .at_min  (at_min)
    );

    // Read-data comparison: which word is expected this cycle and whether it matches.
    always_comb begin
        cmp_en   = 1'b0;
        exp_word = pat_q;
        cmp_addr = addr;
        unique case (state_q)
            R0W1: begin
                cmp_en   = phase_q;
                exp_word = pat_q;
            end
            R1W0: begin
                cmp_en   = phase_q;
                exp_word = ~pat_q;
            end
            RFIN: begin
                cmp_en   = rd_vld_q;
                exp_word = pat_q;
                cmp_addr = rd_addr_q;
            end
            default: ;
        endcase
        mismatch = cmp_en && (RAM_Dout != exp_word);
    end

    // March sequencing: next state, counter commands, RAM strobes and result capture.
    always_comb begin
        // NOTE: every output of this block gets a default first so no latch is inferred.
        state_d     = state_q;
        phase_d     = phase_q;
        tail_d      = 1'b0;
        rd_vld_d    = 1'b0;
        rd_addr_d   = rd_addr_q;
        pat_d       = pat_q;
        pass_d      = pass_q;
        fail_addr_d = fail_addr_q;
        fail_data_d = fail_data_q;
        cnt_load_lo = 1'b0;
        cnt_load_hi = 1'b0;
        cnt_inc     = 1'b0;
        cnt_dec     = 1'b0;
        ram_en      = 1'b0;
        ram_we      = 1'b0;
        ram_din     = '0;

        if (mismatch) begin
            // First mismatch: record it, issue nothing this cycle, finish.
            fail_addr_d = cmp_addr;
            fail_data_d = RAM_Dout;
            pass_d      = 1'b0;
            phase_d     = 1'b0;
            state_d     = DONE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (Start) begin
                        pat_d       = Pattern;
                        pass_d      = 1'b0;
                        fail_addr_d = '0;
                        fail_data_d = '0;
                        phase_d     = 1'b0;
                        cnt_load_lo = 1'b1;
                        state_d     = W0;
                    end
                end
                W0: begin
                    ram_en  = 1'b1;
                    ram_we  = 1'b1;
                    ram_din = pat_q;
                    if (at_max) begin
                        cnt_load_lo = 1'b1;
                        state_d     = R0W1;
                    end else begin
                        cnt_inc = 1'b1;
                    end
                end
                R0W1: begin
                    ram_en = 1'b1;
                    if (!phase_q) begin
                        phase_d = 1'b1;
                    end else begin
                        phase_d = 1'b0;
                        ram_we  = 1'b1;
                        ram_din = ~pat_q;
                        if (at_max) begin
                            cnt_load_hi = 1'b1;
                            state_d     = R1W0;
                        end else begin
                            cnt_inc = 1'b1;
                        end
                    end
                end
                R1W0: begin
                    ram_en = 1'b1;
                    if (!phase_q) begin
                        phase_d = 1'b1;
                    end else begin
                        phase_d = 1'b0;
                        ram_we  = 1'b1;
                        ram_din = pat_q;
                        if (at_min) begin
                            cnt_load_hi = 1'b1;
                            state_d     = RFIN;
                        end else begin
                            cnt_dec = 1'b1;
                        end
                    end
                end
                RFIN: begin
                    if (tail_q) begin
                        pass_d  = 1'b1;
                        state_d = DONE;
                    end else begin
                        ram_en    = 1'b1;
                        rd_vld_d  = 1'b1;
                        rd_addr_d = addr;
                        if (at_min) begin
                            tail_d = 1'b1;
                        end else begin
                            cnt_dec = 1'b1;
                        end
                    end
                end
                DONE: begin
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // State and result registers; reset wins over any in-progress test.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= IDLE;
            phase_q     <= 1'b0;
            tail_q      <= 1'b0;
            rd_vld_q    <= 1'b0;
            rd_addr_q   <= '0;
            pat_q       <= '0;
            pass_q      <= 1'b0;
            fail_addr_q <= '0;
            fail_data_q <= '0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            tail_q      <= tail_d;
            rd_vld_q    <= rd_vld_d;
            rd_addr_q   <= rd_addr_d;
            pat_q       <= pat_d;
            pass_q      <= pass_d;
            fail_addr_q <= fail_addr_d;
            fail_data_q <= fail_data_d;
        end
    end

    assign RAM_EN   = ram_en;
    assign RAM_WE   = ram_we;
    assign RAM_Addr = ram_en ? addr : '0;
    assign RAM_Din  = ram_din;
    assign Busy     = (state_q != IDLE) && (state_q != DONE);
    assign Done     = (state_q == DONE);
    assign Pass     = pass_q;
    assign FailAddr = fail_addr_q;
    assign FailData = fail_data_q;

endmodule

// File: doc/ram_bist.md
RAM_BIST -- requirements
Module: ram_bist

Interface
REQ-001 The parameter AW SHALL default to 8 and set the RAM address width; the RAM depth is N = 2^AW.
REQ-002 The parameter DW SHALL default to 8 and set the RAM data width.
REQ-003 CLK  in  1  single clock; all logic SHALL be rising-edge triggered.
REQ-004 RST  in  1  reset; SHALL be synchronous and active-high.
REQ-005 Start  in  1  a one-cycle pulse that starts a test when the block is idle.
REQ-006 Pattern  in  DW  background data word, latched when Start is accepted.
REQ-007 RAM_EN  out  1  RAM enable.
REQ-008 RAM_WE  out  1  RAM write enable.
REQ-009 RAM_Addr  out  AW  RAM address.
REQ-010 RAM_Din  out  DW  RAM write data.
REQ-011 RAM_Dout  in  DW  RAM read data, valid the cycle after a read is issued.
REQ-012 Busy  out  1  high while a test is in progress.
REQ-013 Done  out  1  one-cycle pulse at test end.
REQ-014 Pass  out  1  test result; SHALL be held until the next accepted Start.
REQ-015 FailAddr  out  AW  address of the first mismatch; SHALL be held until the next accepted Start.
REQ-016 FailData  out  DW  data read at the first mismatch; SHALL be held until the next accepted Start.

Function
REQ-017 The block SHALL act as the initiator of a single-port synchronous RAM with 1-cycle read latency, and SHALL run a March test.
REQ-018 The FSM SHALL have exactly these states: IDLE, W0, R0W1, R1W0, RFIN, DONE.
REQ-019 In IDLE, Start=1 SHALL latch P=Pattern, clear Pass/FailAddr/FailData, and move to W0 with Busy=1 from the next cycle.
REQ-020 W0 SHALL count addresses up from 0 to N-1 and write P, one address per cycle, with EN=1 and WE=1.
REQ-021 R0W1 SHALL count addresses up and spend two cycles per address.
- Cycle A: read the address (EN=1, WE=0).
- Cycle B: compare RAM_Dout against P, then write ~P (EN=1, WE=1).
REQ-022 R1W0 SHALL count addresses down from N-1 to 0 and spend two cycles per address.
- Cycle A: read the address.
- Cycle B: compare against ~P, then write P.
REQ-023 RFIN SHALL count addresses down and read one address per cycle, comparing against P one cycle later; this pipelined element takes N+1 cycles, the last cycle being compare-only with EN=0.
REQ-024 A fault-free test SHALL hold Busy for exactly 6N+1 cycles (1537 cycles for AW=8).
REQ-025 DONE SHALL last one cycle with Done=1 and Busy=0, and SHALL then return to IDLE.
REQ-026 On the first mismatch the block SHALL capture FailAddr and FailData, suppress that cycle's write (WE=0), set Pass=0, and go directly to DONE.
REQ-027 When no mismatch occurs, the block SHALL set Pass=1 in the DONE cycle.
REQ-028 The address counter SHALL NOT wrap: at N-1 when counting up, or at 0 when counting down, the FSM SHALL advance to the next element.
REQ-029 Start SHALL be ignored while the FSM is outside IDLE, including in DONE.
REQ-030 Outside the read and write cycles the block SHALL drive RAM_EN=0 and RAM_WE=0.
REQ-031 Whenever RAM_WE=0, the block SHALL drive RAM_Din to 0.

Reset
REQ-032 RST=1 SHALL, at the next edge, force the FSM to IDLE and drive every output to 0 (RAM_EN, RAM_WE, RAM_Addr, RAM_Din, Busy, Done, Pass, FailAddr, FailData).
REQ-033 RST SHALL take priority over Start and over any in-progress test; an aborted test SHALL produce no Done pulse.

Structure
REQ-034 The package ram_bist_pkg SHALL hold the FSM state enum and the default AW/DW constants.
REQ-035 The up/down address counter with terminal-count flags SHALL be a sub-module named bist_addr_cnt; all other logic SHALL be inline.

Verification
REQ-036 Scenario 1: ideal RAM model, Pattern=0x55, Start -> Busy high for 1537 cycles, then Done with Pass=1.
REQ-037 Scenario 2: bit 3 of address 0x5A stuck at 1, Pattern=0x00 -> Pass=0, FailAddr=0x5A, FailData=0x08; Done asserted during R0W1; no write issued in the fail cycle.
REQ-038 Scenario 3: bit 0 of address 0x00 stuck at 0, Pattern=0xFF -> Pass=0, FailAddr=0x00, FailData=0xFE.
REQ-039 Scenario 4: a Start pulse at cycle 100 of a running test -> ignored; total Busy time still 1537 cycles; Pass=1.
REQ-040 Scenario 5: RST at cycle 700 -> next cycle all outputs 0 and RAM_EN=0, no Done pulse; a subsequent Start completes with Pass=1.
REQ-041 Scenario 6: fault injected only at address 0xFF, bit 7 stuck at 0 after the first write, Pattern=0x80 -> Pass=0, FailAddr=0xFF, FailData=0x00, which exercises the up-count terminal boundary.
